// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Request/acknowledge bus between one data-memory master and the arbiter.
//   Master side drives:  req (held until ack), we, addr (byte address), wdata.
//   Arbiter side drives: ack (one-cycle pulse), err (misaligned, valid with ack),
//                        rdata (valid with ack).
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Serialises two masters (m0 = CPU data path, m1 = UART loader / debug port)
//   onto a single-port synchronous data memory with round-robin priority.
//   Each access takes IDLE -> ISSUE -> RESP; a waiting master is granted
//   straight out of RESP so alternating masters get one access per 2 cycles.
// Ports:
//   clock, reset      system clock, asynchronous active-low reset
//   m0, m1            request/acknowledge buses (slave side)
//   mem_we/addr/wdata memory write enable, word address, write data
//   mem_rdata         memory read data, valid the cycle after address sampling
//   cpu_stall         m0 is requesting and not yet acknowledged
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic              lat_we_q, lat_we_d;
  logic              lat_err_q, lat_err_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;

  logic              grant;
  logic              winner;

  // State and latched-transaction registers. last resets to 1 so that
  // master 0 wins the first tie after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      lat_we_q    <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      lat_we_q    <= lat_we_d;
      lat_err_q   <= lat_err_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Next-state and grant logic. In RESP only the other master is considered:
  // the served master's req is still high for the transaction just acked.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    lat_we_d    = lat_we_q;
    lat_err_d   = lat_err_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    grant       = 1'b0;
    winner      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0.req && m1.req) begin
          grant  = 1'b1;
          winner = ~last_q;
        end else if (m0.req) begin
          grant  = 1'b1;
          winner = 1'b0;
        end else if (m1.req) begin
          grant  = 1'b1;
          winner = 1'b1;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (sel_q ? m0.req : m1.req) begin
          grant  = 1'b1;
          winner = ~sel_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Request fields are captured only here; later changes on the bus
    // do not affect the transaction in flight. Upper address bits wrap.
    if (grant) begin
      state_d     = ISSUE;
      sel_d       = winner;
      last_d      = winner;
      lat_we_d    = winner ? m1.we : m0.we;
      lat_addr_d  = winner ? m1.addr[ADDR_W+1:2] : m0.addr[ADDR_W+1:2];
      lat_wdata_d = winner ? m1.wdata : m0.wdata;
      lat_err_d   = winner ? (m1.addr[1:0] != 2'b00) : (m0.addr[1:0] != 2'b00);
    end
  end

  // Response outputs: only the selected master sees ack/err/rdata, and only in RESP.
  always_comb begin
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rdata = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rdata = '0;
    if (state_q == RESP) begin
      if (sel_q) begin
        m1.ack   = 1'b1;
        m1.err   = lat_err_q;
        m1.rdata = mem_rdata;
      end else begin
        m0.ack   = 1'b1;
        m0.err   = lat_err_q;
        m0.rdata = mem_rdata;
      end
    end
  end

  // Address and data come straight from the latches so they hold between
  // accesses; the write strobe is suppressed for misaligned accesses.
  assign mem_we    = (state_q == ISSUE) && lat_we_q && !lat_err_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;
  assign cpu_stall = m0.req && !m0.ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios for latency, contention order, misalignment, mid-flight
//   bus changes and reset, followed by randomized traffic from both masters
//   checked against a shadow memory and simple transaction rules.
module tb_dmem_arbiter;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int RAND_WORDS = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_stall;

  dmem_arbiter_if #(.DATA_W(DATA_W)) m0_bus ();
  dmem_arbiter_if #(.DATA_W(DATA_W)) m1_bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall)
  );

  always #5 clock = ~clock;

  // Single-port synchronous memory with a backdoor used only while the DUT is in reset.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int          checks = 0;
  int          errors = 0;
  int          we_count = 0;
  int          exp_writes = 0;
  bit          mon_en = 1'b0;
  logic [31:0] ref_mem [RAND_WORDS];
  int          order_q[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Per-cycle bus rules and a count of memory write strobes.
  always @(negedge clock) begin
    if (mon_en) begin
      if (mem_we) we_count++;
      checkOutput("ack_exclusive", 64'(m0_bus.ack & m1_bus.ack), 64'h0);
      if (!m0_bus.ack) begin
        checkOutput("m0_quiet_rdata", 64'(m0_bus.rdata), 64'h0);
        checkOutput("m0_quiet_err", 64'(m0_bus.err), 64'h0);
      end
      if (!m1_bus.ack) begin
        checkOutput("m1_quiet_rdata", 64'(m1_bus.rdata), 64'h0);
        checkOutput("m1_quiet_err", 64'(m1_bus.err), 64'h0);
      end
    end
  end

  function automatic logic ackOf(input int m);
    return (m == 0) ? m0_bus.ack : m1_bus.ack;
  endfunction

  function automatic logic errOf(input int m);
    return (m == 0) ? m0_bus.err : m1_bus.err;
  endfunction

  function automatic logic [31:0] rdataOf(input int m);
    return (m == 0) ? m0_bus.rdata : m1_bus.rdata;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
    end
  endtask

  // Waits for the master's ack; edges = rising edges from request to ack.
  task automatic waitAck(input int m, output int edges, output logic [31:0] rdata, output logic err);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ackOf(m) && n < 12);
    if (!ackOf(m)) checkOutput("ack_timeout", 64'h0, 64'h1);
    edges = n - 1;
    rdata = rdataOf(m);
    err   = errOf(m);
  endtask

  task automatic bdWrite(input int a, input logic [31:0] d);
    bd_addr = ADDR_W'(a);
    bd_data = d;
    bd_we   = 1'b1;
    tick;
    bd_we   = 1'b0;
  endtask

  task automatic initMemory;
    logic [31:0] d;
    for (int i = 0; i < RAND_WORDS; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      bdWrite(i, d);
    end
  endtask

  // Back-to-back reads from one master while the other does the same.
  task automatic contentionMaster(input int m);
    int          ed;
    logic [31:0] rd;
    logic        er;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(m, 1'b1, 1'b0, 32'h14, 32'h0);
      waitAck(m, ed, rd, er);
      if (k == 0) begin
        if (m == 0) checkOutput("m0_first_latency", 64'(ed), 64'd2);
        else        checkOutput("m1_first_latency", 64'(ed), 64'd4);
      end
      checkOutput("contention_rdata", 64'(rd), 64'hDEADBEEF);
      order_q.push_back(m);
      tick;
    end
    applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Random traffic; the shadow memory is updated in acknowledge order.
  task automatic randomDriver(input int m, input int n);
    for (int k = 0; k < n; k++) begin
      logic        we;
      logic [1:0]  low;
      int          word;
      logic [15:0] up;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        er;
      int          ed;
      int          gap;
      we    = 1'($urandom_range(0, 1));
      low   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      word  = $urandom_range(0, RAND_WORDS - 1);
      up    = 16'($urandom);
      addr  = {up, 8'h00, 6'(word), low};
      wdata = $urandom;
      applyStimulus(m, 1'b1, we, addr, wdata);
      waitAck(m, ed, rd, er);
      checkOutput("rand_err", 64'(er), 64'(low != 2'b00));
      checkOutput("rand_latency_ok", 64'(ed <= 4), 64'h1);
      if (!we && low == 2'b00) checkOutput("rand_rdata", 64'(rd), 64'(ref_mem[word]));
      if (we && low == 2'b00) begin
        ref_mem[word] = wdata;
        exp_writes++;
      end
      tick;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (gap) tick;
      end
    end
    applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          ed;
    int          base;
    logic [31:0] rd;
    logic        er;

    reset   = 1'b0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    checkOutput("rst_mem_we", 64'(mem_we), 64'h0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    checkOutput("rst_m0_ack", 64'(m0_bus.ack), 64'h0);
    checkOutput("rst_m1_ack", 64'(m1_bus.ack), 64'h0);
    checkOutput("rst_stall_low", 64'(cpu_stall), 64'h0);
    m0_bus.req = 1'b1;
    #1;
    checkOutput("rst_stall_high", 64'(cpu_stall), 64'h1);
    m0_bus.req = 1'b0;

    initMemory;
    bdWrite(5, 32'hDEADBEEF);
    bdWrite(8, 32'h0BADF00D);
    bdWrite(12, 32'h0);
    mon_en = 1'b1;
    reset  = 1'b1;
    tick;

    $display("[TB] contention after reset");
    fork
      contentionMaster(0);
      contentionMaster(1);
    join
    checkOutput("order_len", 64'(order_q.size()), 64'd6);
    foreach (order_q[i]) checkOutput("order", 64'(order_q[i]), 64'(i % 2));
    tick;

    $display("[TB] single read");
    applyStimulus(0, 1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge clock);
    checkOutput("rd_stall_c0", 64'(cpu_stall), 64'h1);
    checkOutput("rd_noack_c0", 64'(m0_bus.ack), 64'h0);
    @(negedge clock);
    checkOutput("rd_issue_addr", 64'(mem_addr), 64'd5);
    checkOutput("rd_issue_we", 64'(mem_we), 64'h0);
    checkOutput("rd_stall_c1", 64'(cpu_stall), 64'h1);
    @(negedge clock);
    checkOutput("rd_ack", 64'(m0_bus.ack), 64'h1);
    checkOutput("rd_data", 64'(m0_bus.rdata), 64'hDEADBEEF);
    checkOutput("rd_err", 64'(m0_bus.err), 64'h0);
    checkOutput("rd_stall_ack", 64'(cpu_stall), 64'h0);
    tick;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    $display("[TB] write then read");
    base = we_count;
    applyStimulus(1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    waitAck(1, ed, rd, er);
    checkOutput("wr_latency", 64'(ed), 64'd2);
    checkOutput("wr_err", 64'(er), 64'h0);
    checkOutput("wr_we_pulses", 64'(we_count - base), 64'd1);
    tick;
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0);
    waitAck(1, ed, rd, er);
    checkOutput("rdback_latency", 64'(ed), 64'd2);
    checkOutput("rdback_data", 64'(rd), 64'h12345678);
    checkOutput("rdback_we_total", 64'(we_count - base), 64'd1);
    tick;
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    $display("[TB] misaligned write");
    base = we_count;
    applyStimulus(0, 1'b1, 1'b1, 32'h22, 32'hAABBCCDD);
    waitAck(0, ed, rd, er);
    checkOutput("mis_latency", 64'(ed), 64'd2);
    checkOutput("mis_err", 64'(er), 64'h1);
    tick;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    checkOutput("mis_no_we", 64'(we_count - base), 64'd0);
    checkOutput("mis_word8", 64'(mem[8]), 64'h0BADF00D);

    $display("[TB] mid-transaction change");
    applyStimulus(1, 1'b1, 1'b0, 32'h14, 32'h0);
    tick;
    applyStimulus(1, 1'b0, 1'b0, 32'h40, 32'h0);
    @(negedge clock);
    checkOutput("chg_issue_addr", 64'(mem_addr), 64'd5);
    @(negedge clock);
    checkOutput("chg_ack", 64'(m1_bus.ack), 64'h1);
    checkOutput("chg_rdata", 64'(m1_bus.rdata), 64'hDEADBEEF);
    tick;
    tick;

    $display("[TB] reset during ISSUE of a write");
    applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'h55AA55AA);
    tick;
    @(negedge clock);
    checkOutput("midrst_issue_we", 64'(mem_we), 64'h1);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_we", 64'(mem_we), 64'h0);
    checkOutput("midrst_addr", 64'(mem_addr), 64'h0);
    checkOutput("midrst_wdata", 64'(mem_wdata), 64'h0);
    checkOutput("midrst_m0_ack", 64'(m0_bus.ack), 64'h0);
    checkOutput("midrst_m1_ack", 64'(m1_bus.ack), 64'h0);
    checkOutput("midrst_stall", 64'(cpu_stall), 64'h1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("midrst_stall_low", 64'(cpu_stall), 64'h0);
    tick;
    checkOutput("midrst_word12", 64'(mem[12]), 64'h0);
    @(negedge clock);
    checkOutput("midrst_no_ack", 64'(m0_bus.ack), 64'h0);
    tick;
    reset = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
    waitAck(0, ed, rd, er);
    checkOutput("postrst_latency", 64'(ed), 64'd2);
    checkOutput("postrst_rdata", 64'(rd), 64'h0);
    checkOutput("postrst_err", 64'(er), 64'h0);
    tick;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    $display("[TB] randomized traffic");
    reset = 1'b0;
    initMemory;
    reset = 1'b1;
    tick;
    base       = we_count;
    exp_writes = 0;
    fork
      randomDriver(0, 150);
      randomDriver(1, 150);
    join
    tick;
    tick;
    checkOutput("rand_we_count", 64'(we_count - base), 64'(exp_writes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single-port synchronous data memory of the CPU. Master 0 is the CPU data path: ALU result as address, register data as write data, control-unit MemWrite. Master 1 is the I/O side: the UART program/data loader or a debug port. The block serialises their accesses onto one memory port using round-robin priority and a request/acknowledge handshake. It also produces a stall signal for freezing the CPU clock enable / PC while master 0 waits.

## Interface
Parameters:
- ADDR_W, 14, memory word-address width; memory depth is 2^ADDR_W words
- DATA_W, 32, data width

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  master 0 transaction complete, one-cycle pulse
- m0_err  out  1  master 0 misaligned access, valid with m0_ack
- m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same directions, widths and meaning as the m0 ports, for master 1
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address is sampled
- cpu_stall  out  1  m0_req & ~m0_ack

## Operation
FSM states: IDLE, ISSUE, RESP. Registers:
- sel: served master
- last: last-served master
- lat_we, lat_addr, lat_wdata, lat_err: latched transaction fields

IDLE:
- No request: stay in IDLE.
- Exactly one request: grant that master.
- Both requesting: grant the master that is not `last`.
- On grant: latch we/addr/wdata of the winner, latch `err = (addr[1:0] != 0)`, set sel, set last = winner, go to ISSUE.

ISSUE:
- mem_addr = lat_addr[ADDR_W+1:2].
- mem_wdata = lat_wdata.
- mem_we = lat_we & ~lat_err.
- Always go to RESP.

RESP:
- Pulse ack for the `sel` master.
- rdata of that master = mem_rdata. Reads return memory contents; writes return the value read during the write cycle, which is don't-care.
- err of that master = lat_err.
- Next state: if the other master's req = 1, grant it immediately (latch its fields, go to ISSUE). Otherwise go to IDLE.
- The `sel` master's own req is ignored in RESP, because it is still high for the transaction just acknowledged.

Additional rules:
- Outside ISSUE, mem_we = 0. mem_addr and mem_wdata hold their last values.
- Outside RESP, both ack and both err = 0 and both rdata = 0.
- Request fields are sampled only at grant. Changing or dropping req after grant does not abort the transaction.
- Misaligned access: no memory write occurs. It completes with ack = 1, err = 1 and rdata = mem_rdata (don't-care).
- Address bits above ADDR_W+1 are ignored; the address wraps modulo memory size.

## Timing
- Reset (reset = 0, asynchronous): state = IDLE, last = 1 (master 0 wins the first tie), sel = 0, and all lat_* = 0.
- Output values while in reset: mem_we = 0, mem_addr = 0, mem_wdata = 0, all ack/err/rdata = 0, cpu_stall = m0_req.
- Reset release is synchronous to clock.
- Latency:
  - Request seen in IDLE at edge N: ISSUE in cycle N+1, ack in cycle N+2.
  - Memory samples its address and write at the end of ISSUE.
  - Uncontended throughput: one access per 3 cycles.
  - Alternating masters: one access per 2 cycles.
- A master must deassert req, or present a new transaction, in the cycle after its ack. If req is still high in IDLE, it is treated as a new request.
- Reset asserted in ISSUE or RESP: the transaction is abandoned, no ack is produced, and mem_we drops immediately.
- Simultaneous first requests after reset: master 0 is served first, then master 1.

## Test plan
- Single read: preload word 5 = 0xDEADBEEF. m0 read at addr 0x14 -> mem_addr = 5 in ISSUE; m0_ack one cycle later with m0_rdata = 0xDEADBEEF, m0_err = 0; cpu_stall high for 2 cycles.
- Write then read: m1 writes 0x12345678 to 0x40, then m1 reads 0x40 -> mem_we = 1 exactly one cycle; the read returns 0x12345678.
- Contention: m0 and m1 both request from IDLE right after reset -> m0 acked in cycle 2, m1 acked in cycle 4 via RESP->ISSUE. Both repeat -> order alternates m0, m1, m0, m1.
- Misaligned write: m0 writes to 0x22 -> m0_ack = 1 with m0_err = 1, mem_we never asserted, and word 8 is unchanged.
- Mid-transaction change: m1 changes addr and drops req during ISSUE -> the original address is accessed and m1_ack still pulses.
- Reset mid-operation: assert reset during ISSUE of a write -> mem_we drops asynchronously, no ack, FSM in IDLE, all outputs 0; the next request is served normally.
